// File: rtl/keypad_scan.sv
// 4x4 active-low key matrix scanner: drives one column per dwell period, builds a
// frame image of pressed keys and debounces single-key presses and their releases.
module keypad_scan #(
  parameter int SCAN_DIV = 25000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [1:0] dbg_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx;
  logic [15:0]      r_frame;
  state_t           r_state;
  logic [3:0]       r_cand;
  logic [3:0]       r_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_down;

  logic        w_tick;
  logic        w_frame_done;
  logic [15:0] w_frame_next;
  logic [4:0]  w_pop;
  logic [3:0]  w_single_code;
  logic        w_single;
  logic        w_cand_hit;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_frame_done = w_tick && (r_col_idx == 2'd3);

  // The classifier must see the column being stored on this tick, so it works
  // on the frame image as it will be after the update.
  always_comb begin
    w_frame_next = r_frame;
    w_frame_next[{r_col_idx, 2'b00} +: 4] = ~r_row_sync;
  end

  always_comb begin
    w_pop         = '0;
    w_single_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_frame_next[i]) begin
        w_pop         = w_pop + 5'd1;
        w_single_code = 4'(i);
      end
    end
  end

  assign w_single   = (w_pop == 5'd1);
  assign w_cand_hit = w_frame_next[r_cand];

  // Synchronizer, dwell counter, column index and frame image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
      r_div      <= '0;
      r_col_idx  <= '0;
      r_frame    <= '0;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
      if (w_tick) begin
        r_div     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_frame   <= w_frame_next;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Debounce FSM; only advances on a completed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_single_code;
              if (DEB_N == 4'd1) begin
                r_state     <= S_HELD;
                r_cnt       <= '0;
                r_key_code  <= w_single_code;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
              end else begin
                r_state <= S_DEB_PRESS;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_DEB_PRESS: begin
            if (w_single && (w_single_code == r_cand)) begin
              if (r_cnt + 4'd1 == DEB_N) begin
                r_state     <= S_HELD;
                r_cnt       <= '0;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_HELD: begin
            if (!w_cand_hit) begin
              if (DEB_N == 4'd1) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_key_down <= 1'b0;
              end else begin
                r_state <= S_DEB_RELEASE;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_DEB_RELEASE: begin
            if (!w_cand_hit) begin
              if (r_cnt + 4'd1 == DEB_N) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_key_down <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_state <= S_HELD;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign col_out   = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign dbg_state = r_state;

endmodule
